// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the asynchronous SRAM pads.
// The slave modport is the arbiter's view; master is the pipeline and pad side.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              INST_CE;
  logic [31:0]       INST_VADDR;
  logic [DATA_W-1:0] INST_RDATA;
  logic              INST_STALL;

  logic              DATA_CE;
  logic              DATA_WE;
  logic [BE_W-1:0]   DATA_BE;
  logic [31:0]       DATA_VADDR;
  logic [DATA_W-1:0] DATA_WDATA;
  logic [DATA_W-1:0] DATA_RDATA;
  logic              DATA_STALL;

  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [DATA_W-1:0] SRAM_DQ_O;
  logic              SRAM_DQ_OE;
  logic [DATA_W-1:0] SRAM_DQ_I;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;
  logic              SRAM_WE_N;
  logic [BE_W-1:0]   SRAM_BE_N;

  modport master (
    output INST_CE, INST_VADDR,
    input  INST_RDATA, INST_STALL,
    output DATA_CE, DATA_WE, DATA_BE, DATA_VADDR, DATA_WDATA,
    input  DATA_RDATA, DATA_STALL,
    input  SRAM_ADDR, SRAM_DQ_O, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N,
    output SRAM_DQ_I
  );

  modport slave (
    input  INST_CE, INST_VADDR,
    output INST_RDATA, INST_STALL,
    input  DATA_CE, DATA_WE, DATA_BE, DATA_VADDR, DATA_WDATA,
    output DATA_RDATA, DATA_STALL,
    output SRAM_ADDR, SRAM_DQ_O, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_BE_N,
    input  SRAM_DQ_I
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous SRAM between instruction fetch and the data port (data wins),
// sequencing each access over WAIT_CYCLES+1 strobe cycles followed by a one-cycle DONE.
module sram_port_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  sram_port_arbiter_if.slave   bus
);
  localparam int              BE_W      = DATA_W / 8;
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_reg;
  logic                grant_data_reg;
  logic [3:0]          cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                we_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_q_reg;
  logic                inst_done_reg;
  logic                data_done_reg;
  logic                ce_n_reg;
  logic                oe_n_reg;
  logic                we_n_reg;
  logic                dq_oe_reg;
  logic [BE_W-1:0]     be_n_reg;

  // Request selected in IDLE; the data port always takes precedence.
  logic                req_valid;
  logic                req_data;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [BE_W-1:0]     req_be;
  logic [BE_W-1:0]     req_be_n;

  always_comb begin
    req_valid = bus.DATA_CE | bus.INST_CE;
    req_data  = bus.DATA_CE;
    req_we    = 1'b0;
    req_be    = '0;
    req_addr  = bus.INST_VADDR[ADDR_W+1:2];
    if (bus.DATA_CE) begin
      req_we   = bus.DATA_WE;
      req_be   = bus.DATA_BE;
      req_addr = bus.DATA_VADDR[ADDR_W+1:2];
    end
  end

  // Reads enable every byte lane; writes drive only the requested lanes.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_be
      assign req_be_n[gi] = req_we ? ~req_be[gi] : 1'b0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      grant_data_reg <= 1'b0;
      cnt_reg        <= 4'd0;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      rdata_q_reg    <= '0;
      inst_done_reg  <= 1'b0;
      data_done_reg  <= 1'b0;
      ce_n_reg       <= 1'b1;
      oe_n_reg       <= 1'b1;
      we_n_reg       <= 1'b1;
      dq_oe_reg      <= 1'b0;
      be_n_reg       <= '1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            grant_data_reg <= req_data;
            addr_reg       <= req_addr;
            we_reg         <= req_we;
            if (req_data) begin
              wdata_reg <= bus.DATA_WDATA;
            end
            cnt_reg   <= WAIT_INIT;
            ce_n_reg  <= 1'b0;
            oe_n_reg  <= req_we;
            we_n_reg  <= ~req_we;
            dq_oe_reg <= req_we;
            be_n_reg  <= req_be_n;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            if (!we_reg) begin
              rdata_q_reg <= bus.SRAM_DQ_I;
            end
            if (grant_data_reg) begin
              data_done_reg <= 1'b1;
            end else begin
              inst_done_reg <= 1'b1;
            end
            ce_n_reg  <= 1'b1;
            oe_n_reg  <= 1'b1;
            we_n_reg  <= 1'b1;
            dq_oe_reg <= 1'b0;
            be_n_reg  <= '1;
            state_reg <= DONE;
          end else begin
            cnt_reg  <= cnt_reg - 4'd1;
            // WE_N rises one cycle early so address and data are held past the write edge.
            we_n_reg <= ~we_reg | (cnt_reg == 4'd1);
          end
        end
        DONE: begin
          inst_done_reg <= 1'b0;
          data_done_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.INST_RDATA = rdata_q_reg;
  assign bus.DATA_RDATA = rdata_q_reg;
  assign bus.INST_STALL = ~RST & bus.INST_CE & ~inst_done_reg;
  assign bus.DATA_STALL = ~RST & bus.DATA_CE & ~data_done_reg;

  assign bus.SRAM_ADDR  = addr_reg;
  assign bus.SRAM_DQ_O  = wdata_reg;
  assign bus.SRAM_DQ_OE = dq_oe_reg;
  assign bus.SRAM_CE_N  = ce_n_reg;
  assign bus.SRAM_OE_N  = oe_n_reg;
  assign bus.SRAM_WE_N  = we_n_reg;
  assign bus.SRAM_BE_N  = be_n_reg;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed vector table for the WAIT=1 arbiter plus hand sequences for reset
// mid-access and back-to-back fetches on a WAIT=3 instance.
module tb_sram_port_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(32)) ia ();
  sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(32)) ib ();

  sram_port_arbiter #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(1)) u_a (
    .CLK (CLK),
    .RST (RST),
    .bus (ia.slave)
  );

  sram_port_arbiter #(.ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(3)) u_b (
    .CLK (CLK),
    .RST (RST),
    .bus (ib.slave)
  );

  // Strobe nibble = {CE_N, OE_N, WE_N, DQ_OE}
  localparam logic [3:0] IDL = 4'b1110;
  localparam logic [3:0] RD  = 4'b0010;
  localparam logic [3:0] WR  = 4'b0101;
  localparam logic [3:0] WH  = 4'b0111;

  typedef struct {
    logic        rst, ice;
    logic [31:0] iaddr;
    logic        dce, dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr, dwd, dqi;
    logic        e_ist, e_dst;
    logic [3:0]  e_strb, e_ben;
    logic        chk_ad;
    logic [19:0] e_addr;
    logic        chk_dq;
    logic [31:0] e_dqo;
    logic [1:0]  chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ic, input logic [31:0] iad,
                     input logic dc, input logic dw, input logic [3:0] db,
                     input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] dq,
                     input logic eis, input logic eds, input logic [3:0] es, input logic [3:0] eb,
                     input logic ca, input logic [19:0] ea, input logic cd, input logic [31:0] ed,
                     input logic [1:0] cr, input logic [31:0] er);
    vec_t v;
    v.rst = r; v.ice = ic; v.iaddr = iad; v.dce = dc; v.dwe = dw; v.dbe = db;
    v.daddr = da; v.dwd = dwd; v.dqi = dq; v.e_ist = eis; v.e_dst = eds;
    v.e_strb = es; v.e_ben = eb; v.chk_ad = ca; v.e_addr = ea; v.chk_dq = cd;
    v.e_dqo = ed; v.chk_rd = cr; v.e_rd = er;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] strb_a();
    return {ia.SRAM_CE_N, ia.SRAM_OE_N, ia.SRAM_WE_N, ia.SRAM_DQ_OE};
  endfunction

  initial begin
    int dones;
    ia.INST_CE = 0; ia.INST_VADDR = 0; ia.DATA_CE = 0; ia.DATA_WE = 0; ia.DATA_BE = 0;
    ia.DATA_VADDR = 0; ia.DATA_WDATA = 0; ia.SRAM_DQ_I = 0;
    ib.INST_CE = 0; ib.INST_VADDR = 0; ib.DATA_CE = 0; ib.DATA_WE = 0; ib.DATA_BE = 0;
    ib.DATA_VADDR = 0; ib.DATA_WDATA = 0; ib.SRAM_DQ_I = 0;

    //  rst ice iaddr          dce dwe dbe  daddr          wdata          dq_i            ist dst strb ben  ca addr     cd dq_o           rd rdata
    add(1, 0, 32'h0,           0, 0, 4'h0, 32'h0,         32'h0,         32'h0,          0, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         1, 32'h0);
    add(1, 1, 32'h8000_0010,   0, 0, 4'h0, 32'h0,         32'h0,         32'h0,          0, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0010,   0, 0, 4'h0, 32'h0,         32'h0,         32'h2408_0001,  1, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0010,   0, 0, 4'h0, 32'h0,         32'h0,         32'h2408_0001,  1, 0, RD,  4'h0, 1, 20'h4,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0010,   0, 0, 4'h0, 32'h0,         32'h0,         32'h2408_0001,  1, 0, RD,  4'h0, 1, 20'h4,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0010,   0, 0, 4'h0, 32'h0,         32'h0,         32'h0,          0, 0, IDL, 4'hF, 1, 20'h4,  0, 32'h0,         1, 32'h2408_0001);
    add(0, 0, 32'h0,           0, 0, 4'h0, 32'h0,         32'h0,         32'h0,          0, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0020,   1, 0, 4'h0, 32'h8000_0100, 32'h0,         32'h1111_1111,  1, 1, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0020,   1, 0, 4'h0, 32'h8000_0100, 32'h0,         32'h1111_1111,  1, 1, RD,  4'h0, 1, 20'h40, 0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0020,   1, 0, 4'h0, 32'h8000_0100, 32'h0,         32'h1111_1111,  1, 1, RD,  4'h0, 1, 20'h40, 0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0020,   1, 0, 4'h0, 32'h8000_0100, 32'h0,         32'h0,          1, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         2, 32'h1111_1111);
    add(0, 1, 32'h8000_0020,   0, 0, 4'h0, 32'h0,         32'h0,         32'h2222_2222,  1, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0020,   0, 0, 4'h0, 32'h0,         32'h0,         32'h2222_2222,  1, 0, RD,  4'h0, 1, 20'h8,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0020,   0, 0, 4'h0, 32'h0,         32'h0,         32'h2222_2222,  1, 0, RD,  4'h0, 1, 20'h8,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0020,   0, 0, 4'h0, 32'h0,         32'h0,         32'h0,          0, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         1, 32'h2222_2222);
    add(0, 0, 32'h0,           0, 0, 4'h0, 32'h0,         32'h0,         32'h0,          0, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);
    add(0, 0, 32'h0,           1, 1, 4'h3, 32'h8000_0200, 32'hDEAD_BEEF, 32'h0,          0, 1, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);
    add(0, 0, 32'h0,           1, 1, 4'hF, 32'h8000_0300, 32'h1234_5678, 32'h0,          0, 1, WR,  4'hC, 1, 20'h80, 1, 32'hDEAD_BEEF, 0, 32'h0);
    add(0, 0, 32'h0,           1, 1, 4'hF, 32'h8000_0300, 32'h1234_5678, 32'h0,          0, 1, WH,  4'hC, 1, 20'h80, 1, 32'hDEAD_BEEF, 0, 32'h0);
    add(0, 0, 32'h0,           1, 1, 4'hF, 32'h8000_0300, 32'h1234_5678, 32'h0,          0, 0, IDL, 4'hF, 1, 20'h80, 1, 32'hDEAD_BEEF, 0, 32'h0);
    add(0, 0, 32'h0,           0, 0, 4'h0, 32'h0,         32'h0,         32'h0,          0, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);
    add(0, 1, 32'h8000_0040,   0, 0, 4'h0, 32'h0,         32'h0,         32'h3333_3333,  1, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);
    add(0, 0, 32'h8000_0040,   0, 0, 4'h0, 32'h0,         32'h0,         32'h3333_3333,  0, 0, RD,  4'h0, 1, 20'h10, 0, 32'h0,         0, 32'h0);
    add(0, 0, 32'h8000_0040,   0, 0, 4'h0, 32'h0,         32'h0,         32'h3333_3333,  0, 0, RD,  4'h0, 1, 20'h10, 0, 32'h0,         0, 32'h0);
    add(0, 0, 32'h8000_0040,   0, 0, 4'h0, 32'h0,         32'h0,         32'h0,          0, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         1, 32'h3333_3333);
    add(0, 0, 32'h0,           0, 0, 4'h0, 32'h0,         32'h0,         32'h0,          0, 0, IDL, 4'hF, 0, 20'h0,  0, 32'h0,         0, 32'h0);

    step();
    for (int i = 0; i < vq.size(); i++) begin
      RST = vq[i].rst;
      ia.INST_CE = vq[i].ice; ia.INST_VADDR = vq[i].iaddr;
      ia.DATA_CE = vq[i].dce; ia.DATA_WE = vq[i].dwe; ia.DATA_BE = vq[i].dbe;
      ia.DATA_VADDR = vq[i].daddr; ia.DATA_WDATA = vq[i].dwd; ia.SRAM_DQ_I = vq[i].dqi;
      #4;
      $display("[TB] vec %0d rst=%0b ice=%0b dce=%0b we=%0b ist=%0b dst=%0b strb=%b be_n=%b addr=%h",
               i, vq[i].rst, vq[i].ice, vq[i].dce, vq[i].dwe, ia.INST_STALL, ia.DATA_STALL,
               strb_a(), ia.SRAM_BE_N, ia.SRAM_ADDR);
      check($sformatf("v%0d inst_stall", i), 64'(ia.INST_STALL), 64'(vq[i].e_ist));
      check($sformatf("v%0d data_stall", i), 64'(ia.DATA_STALL), 64'(vq[i].e_dst));
      check($sformatf("v%0d strobes", i), 64'(strb_a()), 64'(vq[i].e_strb));
      check($sformatf("v%0d be_n", i), 64'(ia.SRAM_BE_N), 64'(vq[i].e_ben));
      if (vq[i].chk_ad) check($sformatf("v%0d sram_addr", i), 64'(ia.SRAM_ADDR), 64'(vq[i].e_addr));
      if (vq[i].chk_dq) check($sformatf("v%0d dq_o", i), 64'(ia.SRAM_DQ_O), 64'(vq[i].e_dqo));
      if (vq[i].chk_rd == 2'd1) check($sformatf("v%0d inst_rdata", i), 64'(ia.INST_RDATA), 64'(vq[i].e_rd));
      if (vq[i].chk_rd == 2'd2) check($sformatf("v%0d data_rdata", i), 64'(ia.DATA_RDATA), 64'(vq[i].e_rd));
      step();
    end

    // Reset asserted during the second ACCESS cycle of a fetch.
    ia.INST_CE = 1; ia.INST_VADDR = 32'h8000_0080; ia.SRAM_DQ_I = 32'h5555_5555;
    #4; check("rst_seq idle stall", 64'(ia.INST_STALL), 64'd1);
    step();
    #4; check("rst_seq access1 strobes", 64'(strb_a()), 64'(RD));
    step();
    RST = 1;
    #4; check("rst_seq access2 strobes", 64'(strb_a()), 64'(RD));
    check("rst_seq stall forced", 64'(ia.INST_STALL), 64'd0);
    step();
    RST = 0; ia.INST_VADDR = 32'h8000_0084; ia.SRAM_DQ_I = 32'h4444_4444;
    #4; $display("[TB] reset mid-access: strb=%b dq_oe=%0b", strb_a(), ia.SRAM_DQ_OE);
    check("rst_seq strobes idle", 64'(strb_a()), 64'(IDL));
    check("rst_seq be_n idle", 64'(ia.SRAM_BE_N), 64'hF);
    check("rst_seq rdata cleared", 64'(ia.INST_RDATA), 64'd0);
    check("rst_seq back in idle", 64'(ia.INST_STALL), 64'd1);
    step();
    #4; check("rst_seq refetch strobes", 64'(strb_a()), 64'(RD));
    check("rst_seq refetch addr", 64'(ia.SRAM_ADDR), 64'h21);
    step();
    #4; check("rst_seq refetch hold stall", 64'(ia.INST_STALL), 64'd1);
    step();
    #4; $display("[TB] refetch after reset: stall=%0b rdata=%h", ia.INST_STALL, ia.INST_RDATA);
    check("rst_seq refetch done stall", 64'(ia.INST_STALL), 64'd0);
    check("rst_seq refetch rdata", 64'(ia.INST_RDATA), 64'h4444_4444);
    ia.INST_CE = 0;
    step();
    step();

    // WAIT_CYCLES=3 instance: two back-to-back fetches with CE held.
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      int ph;
      logic act;
      ph  = c % 6;
      act = (ph >= 1) && (ph <= 4);
      ib.INST_CE = 1; ib.INST_VADDR = 32'h8000_0000;
      ib.SRAM_DQ_I = (c < 6) ? 32'h0000_00A0 : 32'h0000_00B0;
      #4;
      $display("[TB] wait3 cycle %0d stall=%0b ce_n=%0b oe_n=%0b we_n=%0b", c, ib.INST_STALL,
               ib.SRAM_CE_N, ib.SRAM_OE_N, ib.SRAM_WE_N);
      if (!ib.INST_STALL) dones++;
      check($sformatf("w3 c%0d stall", c), 64'(ib.INST_STALL), 64'(ph != 5));
      check($sformatf("w3 c%0d ce_n", c), 64'(ib.SRAM_CE_N), 64'(!act));
      check($sformatf("w3 c%0d oe_n", c), 64'(ib.SRAM_OE_N), 64'(!act));
      check($sformatf("w3 c%0d we_n", c), 64'(ib.SRAM_WE_N), 64'd1);
      if (ph == 5) check($sformatf("w3 c%0d rdata", c), 64'(ib.INST_RDATA), (c < 6) ? 64'hA0 : 64'hB0);
      step();
    end
    check("w3 done cycles", 64'(dones), 64'd2);
    ib.INST_CE = 0;
    #4; check("w3 idle after drop", 64'(ib.SRAM_CE_N), 64'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
